// File: rtl/rkv_tgt_pkg.sv
// Shared types and constants for the rkv request/grant target.
package rkv_tgt_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned IDX_FIELD_W = 7;
  localparam int unsigned ADDR_WR_BIT = 7;
  localparam int unsigned CNT_W       = 4;
  localparam logic [DATA_W-1:0] ERR_DATA = 8'hFF;
  localparam logic [DATA_W-1:0] ERR_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    GRANT,
    RELEASE
  } rkv_tgt_state_e;

  // Transaction captured at the acceptance edge.
  typedef struct packed {
    logic                   wr;
    logic [IDX_FIELD_W-1:0] idx;
    logic [DATA_W-1:0]      data;
  } rkv_tgt_req_t;

  // Any index bit at or above the storage index width marks an out-of-range access.
  function automatic logic idx_bad(input logic [IDX_FIELD_W-1:0] idx, input int unsigned idx_w);
    return (idx >> idx_w) != IDX_FIELD_W'(0);
  endfunction

endpackage

// File: rtl/rkv_tgt_regfile.sv
// DEPTH x DATA_W register file: synchronous write, combinational read, synchronous clear.
module rkv_tgt_regfile
  import rkv_tgt_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/rkv_req_target.sv
// Request/grant bus target with fixed wait states and a local register file.
// Optional saturating error counter enabled by RKV_TGT_ERR_CNT_EN.
module rkv_req_target
  import rkv_tgt_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              grt,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              busy,
  output logic              err
`ifdef RKV_TGT_ERR_CNT_EN
  ,
  output logic [DATA_W-1:0] err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  rkv_tgt_state_e    state;
  logic [CNT_W-1:0]  cnt;
  rkv_tgt_req_t      cap;
  logic              bad_c;
  logic              we_c;
  logic [DATA_W-1:0] rdata_c;

  assign bad_c = idx_bad(cap.idx, IDX_W);
  // Write commits on the edge that ends the GRANT state; bad addresses never reach storage.
  assign we_c  = (state == GRANT) && cap.wr && !bad_c;

  rkv_tgt_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we_c),
    .addr    (cap.idx[IDX_W-1:0]),
    .wdata   (cap.data),
    .rdata_c (rdata_c)
  );

  // Outputs are registered off the state being left, so grt lands one edge after GRANT is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap      <= '0;
      grt      <= 1'b0;
      data_out <= '0;
      data_oe  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      grt      <= 1'b0;
      err      <= 1'b0;
      data_oe  <= 1'b0;
      data_out <= '0;
      case (state)
        IDLE: begin
          if (req) begin
            cap.wr   <= addr[ADDR_WR_BIT];
            cap.idx  <= addr[IDX_FIELD_W-1:0];
            cap.data <= data_in;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= GRANT;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= GRANT;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GRANT: begin
          grt   <= 1'b1;
          err   <= bad_c;
          state <= RELEASE;
          if (!cap.wr) begin
            data_oe  <= 1'b1;
            data_out <= bad_c ? ERR_DATA : rdata_c;
          end
        end
        RELEASE: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RKV_TGT_ERR_CNT_EN
  // Counts err pulses, sticking at full scale until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state == GRANT) && bad_c && (err_cnt != ERR_CNT_MAX)) begin
      err_cnt <= err_cnt + DATA_W'(1);
    end
  end
`endif

endmodule
